mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  N-requester arbiter for the 128-bit DRAM request path (UART loader, D-cache, future DMA) in front of axi_bus_top.
//  Captures each requester's start pulse plus addr/data/mask into a private slot and grants round-robin.
//  Issues one transaction at a time downstream and routes finish/read-data pulses back to the owner.
// PARAMETERS
//  NREQ       2     number of requesters (1..8); requester 0 is first after reset
//  AWIDTH     32    address width
//  DWIDTH     128   data width; mask width = DWIDTH/8
//  TO_CYCLES  1024  watchdog limit, in clk cycles (used only with MEM_ARB_TIMEOUT_EN)
// PORTS
//  clk               in   1              system clock
//  rst               in   1              asynchronous reset, active-high
//  req_wstart_rq     in   NREQ           per-requester write start pulse
//  req_win_addr      in   NREQ*AWIDTH    write address; slice i belongs to requester i
//  req_in_wdata      in   NREQ*DWIDTH    write data
//  req_in_mask       in   NREQ*DWIDTH/8  write byte mask; 1 = byte masked
//  req_finish_wresp  out  NREQ           write-done pulse to owner
//  req_rstart_rq     in   NREQ           per-requester read start pulse
//  req_rin_addr      in   NREQ*AWIDTH    read address
//  req_rdat_m_data   out  DWIDTH         registered read data, broadcast to all
//  req_rdat_m_valid  out  NREQ           read-beat valid to owner
//  req_finish_mrd    out  NREQ           read-done pulse to owner
//  m_wstart_rq       out  1              downstream write start pulse
//  m_win_addr        out  AWIDTH         downstream write addr; held until finish
//  m_in_wdata        out  DWIDTH         downstream write data; held until finish
//  m_in_mask         out  DWIDTH/8       downstream write mask; held until finish
//  m_finish_wresp    in   1              downstream write-done pulse
//  m_rstart_rq       out  1              downstream read start pulse
//  m_rin_addr        out  AWIDTH         downstream read addr; held until finish
//  m_rdat_m_data     in   DWIDTH         downstream read data
//  m_rdat_m_valid    in   1              downstream read-beat valid
//  m_finish_mrd      in   1              downstream read-done pulse
//  busy              out  1              a transaction is outstanding
//  owner             out  3              index of current or last grantee
//  overrun_err       out  1              sticky: a start pulse was dropped
//  timeout_err       out  1              sticky: watchdog fired
//  err_clr           in   1              one-cycle pulse clears both sticky errors
// BEHAVIOUR
//  - Reset: every output, slot, pending bit and error bit is 0. owner=0. RR pointer=0. FSM=IDLE.
//  - Slots: each requester has a write slot and a read slot.
//    Start pulse with the slot free -> capture addr/data/mask, pending=1 on the next edge.
//    Start pulse with the slot pending -> pulse dropped, slot unchanged, overrun_err=1.
//    Start pulse in the same cycle the slot completes -> accepted (set wins over clear).
//  - Arbitration in IDLE: search from RR pointer upward, with wrap, for the first requester with any pending slot.
//    Within one requester, write is served before read.
//  - FSM states: IDLE -> WISSUE|RISSUE -> WWAIT|RWAIT -> IDLE.
//    ISSUE: one-cycle m_wstart_rq/m_rstart_rq pulse; m_* addr/data/mask driven from the slot.
//    WAIT: m_* held stable until the matching downstream finish arrives.
//  - Latency: requester pulse at cycle t -> pending at t+1 -> downstream start pulse at t+2 (idle arbiter).
//  - Completion: downstream finish at cycle u -> owner's req_finish_* pulse at u+1, slot freed, FSM=IDLE.
//    RR pointer moves to owner+1 (mod NREQ). Next issue no earlier than u+2.
//  - Read beats: each m_rdat_m_valid copies m_rdat_m_data to req_rdat_m_data and pulses req_rdat_m_valid[owner] one cycle later.
//    Any number of beats before m_finish_mrd are forwarded in order.
//  - Finishes that do not match the state (e.g. m_finish_mrd in WWAIT, or any finish in IDLE): ignored.
//  - busy = (FSM != IDLE).
//  - err_clr in the same cycle as a new error event: the error is set (set wins).
//  - rst mid-transaction: in-flight transaction and pending slots are discarded; no finish pulse is generated.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - A 16-bit counter clears at ISSUE and counts in WAIT.
//   - On reaching TO_CYCLES: synthetic req_finish_* pulse to owner, slot freed, timeout_err=1, FSM=IDLE.
//   - A late downstream finish after a timeout is ignored.
//  MEM_ARB_TIMEOUT_EN undefined: no counter; WAIT is held indefinitely; timeout_err tied to 0.
// TESTING
//  - NREQ=2, write pulse req0 addr 0x100 data 0xA5.. at t -> m_wstart_rq at t+2, m_win_addr=0x100.
//    Finish at u -> req_finish_wresp=2'b01 at u+1.
//  - Simultaneous write pulses req0 and req1 -> req0 served first, then req1.
//    A second req0 write after req0 completes is served after req1 (round-robin).
//  - Same-cycle write and read pulses on req1 -> write issued first.
//    Read: 4 valid beats -> 4 req_rdat_m_valid=2'b10 pulses, data in order, then req_finish_mrd=2'b10.
//  - Second write pulse on req0 while its write is pending -> overrun_err=1, m_* unchanged.
//    err_clr -> overrun_err=0.
//  - Assert rst during RWAIT -> all outputs 0 next cycle. After release, a new request issues normally.
//  - With MEM_ARB_TIMEOUT_EN, TO_CYCLES=16, no downstream finish -> synthetic req_finish_wresp 16 cycles after ISSUE, timeout_err=1.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter that funnels NREQ requesters onto one DRAM request port, one transaction at a time.
// Define MEM_ARB_TIMEOUT_EN to add a watchdog that retires transactions stuck in WAIT.
module mem_req_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned DWIDTH    = 128,
  parameter int unsigned TO_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_wstart_rq,
  input  logic [NREQ*AWIDTH-1:0]   req_win_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_in_wdata,
  input  logic [NREQ*DWIDTH/8-1:0] req_in_mask,
  output logic [NREQ-1:0]          req_finish_wresp,
  input  logic [NREQ-1:0]          req_rstart_rq,
  input  logic [NREQ*AWIDTH-1:0]   req_rin_addr,
  output logic [DWIDTH-1:0]        req_rdat_m_data,
  output logic [NREQ-1:0]          req_rdat_m_valid,
  output logic [NREQ-1:0]          req_finish_mrd,
  output logic                     m_wstart_rq,
  output logic [AWIDTH-1:0]        m_win_addr,
  output logic [DWIDTH-1:0]        m_in_wdata,
  output logic [DWIDTH/8-1:0]      m_in_mask,
  input  logic                     m_finish_wresp,
  output logic                     m_rstart_rq,
  output logic [AWIDTH-1:0]        m_rin_addr,
  input  logic [DWIDTH-1:0]        m_rdat_m_data,
  input  logic                     m_rdat_m_valid,
  input  logic                     m_finish_mrd,
  output logic                     busy,
  output logic [2:0]               owner,
  output logic                     overrun_err,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int unsigned MWIDTH = DWIDTH / 8;
  localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || NREQ > 8 || TO_CYCLES < 2) begin : g_bad_param
    $error("mem_req_arbiter: NREQ must be 1..8 and TO_CYCLES at least 2");
  end

  typedef enum logic [2:0] {IDLE, WISSUE, WWAIT, RISSUE, RWAIT} state_t;

  state_t state, state_nxt;

  logic [NREQ-1:0]   wpend, rpend;
  logic [AWIDTH-1:0] waddr [NREQ];
  logic [DWIDTH-1:0] wdata [NREQ];
  logic [MWIDTH-1:0] wmask [NREQ];
  logic [AWIDTH-1:0] raddr [NREQ];

  logic [IW-1:0]   rr, cur;
  logic [IW-1:0]   idx_c, gidx_c;
  logic            found_c, gwrite_c, grant_c;
  logic            wdone_c, rdone_c, beat_ok_c, to_hit_c, ovr_evt_c;
  logic [NREQ-1:0] wclr_c, rclr_c, beat_c;
  logic [NREQ-1:0] wfree_c, rfree_c, wacc_c, racc_c;

  // Round-robin search from rr upward with wrap; write wins over read within a requester.
  always_comb begin
    found_c  = 1'b0;
    gidx_c   = '0;
    gwrite_c = 1'b0;
    idx_c    = rr;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!found_c && (wpend[idx_c] || rpend[idx_c])) begin
        found_c  = 1'b1;
        gidx_c   = idx_c;
        gwrite_c = wpend[idx_c];
      end
      idx_c = (idx_c == IW'(NREQ - 1)) ? '0 : idx_c + 1'b1;
    end
  end

  assign grant_c   = (state == IDLE) && found_c;
  assign wdone_c   = (state == WWAIT) && (m_finish_wresp || to_hit_c);
  assign rdone_c   = (state == RWAIT) && (m_finish_mrd || to_hit_c);
  assign beat_ok_c = m_rdat_m_valid && (state == RISSUE || state == RWAIT);

  // Per-requester completion and beat routing to the current owner.
  always_comb begin
    wclr_c = '0;
    rclr_c = '0;
    beat_c = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      wclr_c[i] = wdone_c && (cur == IW'(i));
      rclr_c[i] = rdone_c && (cur == IW'(i));
      beat_c[i] = beat_ok_c && (cur == IW'(i));
    end
  end

  // A slot completing this cycle counts as free, so a same-cycle start is accepted.
  assign wfree_c   = ~wpend | wclr_c;
  assign rfree_c   = ~rpend | rclr_c;
  assign wacc_c    = req_wstart_rq & wfree_c;
  assign racc_c    = req_rstart_rq & rfree_c;
  assign ovr_evt_c = |(req_wstart_rq & ~wfree_c) || |(req_rstart_rq & ~rfree_c);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found_c) state_nxt = gwrite_c ? WISSUE : RISSUE;
      WISSUE:  state_nxt = WWAIT;
      WWAIT:   if (wdone_c) state_nxt = IDLE;
      RISSUE:  state_nxt = RWAIT;
      RWAIT:   if (rdone_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wpend <= '0;
      rpend <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        waddr[i] <= '0;
        wdata[i] <= '0;
        wmask[i] <= '0;
        raddr[i] <= '0;
      end
    end else begin
      wpend <= (wpend & ~wclr_c) | wacc_c;
      rpend <= (rpend & ~rclr_c) | racc_c;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (wacc_c[i]) begin
          waddr[i] <= req_win_addr[i*AWIDTH +: AWIDTH];
          wdata[i] <= req_in_wdata[i*DWIDTH +: DWIDTH];
          wmask[i] <= req_in_mask[i*MWIDTH +: MWIDTH];
        end
        if (racc_c[i]) raddr[i] <= req_rin_addr[i*AWIDTH +: AWIDTH];
      end
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      rr               <= '0;
      cur              <= '0;
      owner            <= '0;
      busy             <= 1'b0;
      m_wstart_rq      <= 1'b0;
      m_rstart_rq      <= 1'b0;
      m_win_addr       <= '0;
      m_in_wdata       <= '0;
      m_in_mask        <= '0;
      m_rin_addr       <= '0;
      req_finish_wresp <= '0;
      req_finish_mrd   <= '0;
      req_rdat_m_valid <= '0;
      req_rdat_m_data  <= '0;
      overrun_err      <= 1'b0;
    end else begin
      state            <= state_nxt;
      busy             <= (state_nxt != IDLE);
      m_wstart_rq      <= (state_nxt == WISSUE);
      m_rstart_rq      <= (state_nxt == RISSUE);
      req_finish_wresp <= wclr_c;
      req_finish_mrd   <= rclr_c;
      req_rdat_m_valid <= beat_c;
      if (beat_ok_c) req_rdat_m_data <= m_rdat_m_data;
      if (grant_c) begin
        cur   <= gidx_c;
        owner <= 3'(gidx_c);
        if (gwrite_c) begin
          m_win_addr <= waddr[gidx_c];
          m_in_wdata <= wdata[gidx_c];
          m_in_mask  <= wmask[gidx_c];
        end else begin
          m_rin_addr <= raddr[gidx_c];
        end
      end
      if (wdone_c || rdone_c) rr <= (cur == IW'(NREQ - 1)) ? '0 : cur + 1'b1;
      overrun_err <= ovr_evt_c || (overrun_err && !err_clr);
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        to_evt_c;

  // Counter sits at 0 while idle, so it reads k on the k-th cycle after the issue pulse.
  assign to_hit_c = (state == WWAIT || state == RWAIT) && (to_cnt == 16'(TO_CYCLES - 1));
  assign to_evt_c = to_hit_c && !((state == WWAIT) ? m_finish_wresp : m_finish_mrd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= (state == IDLE) ? '0 : to_cnt + 16'd1;
      timeout_err <= to_evt_c || (timeout_err && !err_clr);
    end
  end
`else
  assign to_hit_c    = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: scoreboard queues per output channel, checked by a negedge monitor.
module tb_mem_req_arbiter;
  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 128;
  localparam int unsigned MW   = DW / 8;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO   = 16;
`else
  localparam int unsigned TO   = 1024;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_wstart_rq, req_rstart_rq;
  logic [NREQ*AW-1:0] req_win_addr, req_rin_addr;
  logic [NREQ*DW-1:0] req_in_wdata;
  logic [NREQ*MW-1:0] req_in_mask;
  logic [NREQ-1:0]    req_finish_wresp, req_rdat_m_valid, req_finish_mrd;
  logic [DW-1:0]      req_rdat_m_data;
  logic               m_wstart_rq, m_rstart_rq;
  logic [AW-1:0]      m_win_addr, m_rin_addr;
  logic [DW-1:0]      m_in_wdata, m_rdat_m_data;
  logic [MW-1:0]      m_in_mask;
  logic               m_finish_wresp, m_rdat_m_valid, m_finish_mrd;
  logic               busy, overrun_err, timeout_err, err_clr;
  logic [2:0]         owner;

  mem_req_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_wstart_rq(req_wstart_rq), .req_win_addr(req_win_addr), .req_in_wdata(req_in_wdata),
    .req_in_mask(req_in_mask), .req_finish_wresp(req_finish_wresp),
    .req_rstart_rq(req_rstart_rq), .req_rin_addr(req_rin_addr),
    .req_rdat_m_data(req_rdat_m_data), .req_rdat_m_valid(req_rdat_m_valid), .req_finish_mrd(req_finish_mrd),
    .m_wstart_rq(m_wstart_rq), .m_win_addr(m_win_addr), .m_in_wdata(m_in_wdata), .m_in_mask(m_in_mask),
    .m_finish_wresp(m_finish_wresp), .m_rstart_rq(m_rstart_rq), .m_rin_addr(m_rin_addr),
    .m_rdat_m_data(m_rdat_m_data), .m_rdat_m_valid(m_rdat_m_valid), .m_finish_mrd(m_finish_mrd),
    .busy(busy), .owner(owner), .overrun_err(overrun_err), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [MW-1:0] mask; int cyc; } mexp_t;
  typedef struct { logic [NREQ-1:0] vec; logic [DW-1:0] data; int cyc; } pexp_t;

  mexp_t q_mw[$], q_mr[$];
  pexp_t q_fw[$], q_fr[$], q_rv[$];
  mexp_t me;
  pexp_t pe;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic exp_mw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m, input int c);
    mexp_t e;
    e.addr = a; e.data = d; e.mask = m; e.cyc = c;
    q_mw.push_back(e);
  endtask

  task automatic exp_mr(input logic [AW-1:0] a, input int c);
    mexp_t e;
    e.addr = a; e.data = '0; e.mask = '0; e.cyc = c;
    q_mr.push_back(e);
  endtask

  task automatic exp_fw(input logic [NREQ-1:0] v, input int c);
    pexp_t e;
    e.vec = v; e.data = '0; e.cyc = c;
    q_fw.push_back(e);
  endtask

  task automatic exp_fr(input logic [NREQ-1:0] v, input int c);
    pexp_t e;
    e.vec = v; e.data = '0; e.cyc = c;
    q_fr.push_back(e);
  endtask

  task automatic exp_rv(input logic [NREQ-1:0] v, input logic [DW-1:0] d, input int c);
    pexp_t e;
    e.vec = v; e.data = d; e.cyc = c;
    q_rv.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_w(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_wstart_rq[r]          = 1'b1;
    req_win_addr[r*AW +: AW]  = a;
    req_in_wdata[r*DW +: DW]  = d;
    req_in_mask[r*MW +: MW]   = m;
  endtask

  task automatic set_r(input int r, input logic [AW-1:0] a);
    req_rstart_rq[r]         = 1'b1;
    req_rin_addr[r*AW +: AW] = a;
  endtask

  task automatic clr_in();
    req_wstart_rq  = '0;
    req_rstart_rq  = '0;
    m_finish_wresp = 1'b0;
    m_finish_mrd   = 1'b0;
    m_rdat_m_valid = 1'b0;
    err_clr        = 1'b0;
  endtask

  // Every DUT output event must match the head of its channel queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_wstart_rq) begin
        chk1("mw_expected", q_mw.size() != 0, 1'b1);
        if (q_mw.size() != 0) begin
          me = q_mw.pop_front();
          chk("mw_addr", DW'(m_win_addr), DW'(me.addr));
          chk("mw_data", m_in_wdata, me.data);
          chk("mw_mask", DW'(m_in_mask), DW'(me.mask));
          chk("mw_cycle", DW'(cyc), DW'(me.cyc));
        end
      end
      if (m_rstart_rq) begin
        chk1("mr_expected", q_mr.size() != 0, 1'b1);
        if (q_mr.size() != 0) begin
          me = q_mr.pop_front();
          chk("mr_addr", DW'(m_rin_addr), DW'(me.addr));
          chk("mr_cycle", DW'(cyc), DW'(me.cyc));
        end
      end
      if (|req_finish_wresp) begin
        chk1("fw_expected", q_fw.size() != 0, 1'b1);
        if (q_fw.size() != 0) begin
          pe = q_fw.pop_front();
          chk("fw_vec", DW'(req_finish_wresp), DW'(pe.vec));
          chk("fw_cycle", DW'(cyc), DW'(pe.cyc));
        end
      end
      if (|req_finish_mrd) begin
        chk1("fr_expected", q_fr.size() != 0, 1'b1);
        if (q_fr.size() != 0) begin
          pe = q_fr.pop_front();
          chk("fr_vec", DW'(req_finish_mrd), DW'(pe.vec));
          chk("fr_cycle", DW'(cyc), DW'(pe.cyc));
        end
      end
      if (|req_rdat_m_valid) begin
        chk1("rv_expected", q_rv.size() != 0, 1'b1);
        if (q_rv.size() != 0) begin
          pe = q_rv.pop_front();
          chk("rv_vec", DW'(req_rdat_m_valid), DW'(pe.vec));
          chk("rv_data", req_rdat_m_data, pe.data);
          chk("rv_cycle", DW'(cyc), DW'(pe.cyc));
        end
      end
    end
  end

  initial begin
    int t, u;
    logic [DW-1:0] d;
    rst = 1'b1;
    req_win_addr = '0; req_in_wdata = '0; req_in_mask = '0; req_rin_addr = '0;
    m_rdat_m_data = '0;
    clr_in();
    tick(3);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_owner", DW'(owner), DW'(0));
    chk1("rst_overrun", overrun_err, 1'b0);
    chk1("rst_timeout", timeout_err, 1'b0);
    chk1("rst_mwstart", m_wstart_rq, 1'b0);
    chk("rst_mwaddr", DW'(m_win_addr), DW'(0));
    chk("rst_rdata", req_rdat_m_data, DW'(0));
    rst = 1'b0;
    tick(2);

    // Single write on req0: issue at t+2, finish pulse one cycle after downstream finish.
    t = cyc;
    set_w(0, 32'h100, {16{8'hA5}}, 16'h0000);
    exp_mw(32'h100, {16{8'hA5}}, 16'h0000, t + 2);
    tick(1); clr_in();
    chk1("b_idle_t1", busy, 1'b0);
    tick(1);
    chk1("b_busy", busy, 1'b1);
    chk("b_owner", DW'(owner), DW'(0));
    tick(1);
    u = cyc;
    m_finish_wresp = 1'b1;
    exp_fw(2'b01, u + 1);
    tick(1); clr_in();
    chk1("b_done_idle", busy, 1'b0);
    tick(2);

    // req1 write+read same cycle: write first; stray read finish during WWAIT ignored; 4 read beats.
    t = cyc;
    set_w(1, 32'h200, {4{32'hDEADBEEF}}, 16'h00FF);
    set_r(1, 32'h300);
    exp_mw(32'h200, {4{32'hDEADBEEF}}, 16'h00FF, t + 2);
    tick(1); clr_in();
    tick(2);
    m_finish_mrd = 1'b1;
    tick(1); clr_in();
    chk1("c_stray_fin_busy", busy, 1'b1);
    u = cyc;
    m_finish_wresp = 1'b1;
    exp_fw(2'b10, u + 1);
    exp_mr(32'h300, u + 2);
    tick(1); clr_in();
    tick(2);
    for (int i = 0; i < 4; i++) begin
      d = {4{32'h1111_0000 + 32'(i)}};
      m_rdat_m_valid = 1'b1;
      m_rdat_m_data = d;
      exp_rv(2'b10, d, cyc + 1);
      tick(1);
    end
    clr_in();
    u = cyc;
    m_finish_mrd = 1'b1;
    exp_fr(2'b10, u + 1);
    tick(1); clr_in();
    tick(2);
    chk1("c_done_idle", busy, 1'b0);

    // Simultaneous writes from pointer 0; req0 re-requests on its finish cycle but req1 goes next.
    t = cyc;
    set_w(0, 32'h400, {8{16'h4444}}, 16'h0000);
    set_w(1, 32'h500, {8{16'h5555}}, 16'hF00F);
    exp_mw(32'h400, {8{16'h4444}}, 16'h0000, t + 2);
    exp_mw(32'h500, {8{16'h5555}}, 16'hF00F, t + 5);
    tick(1); clr_in();
    tick(2);
    u = cyc;
    m_finish_wresp = 1'b1;
    set_w(0, 32'h600, {8{16'h6666}}, 16'hAAAA);
    exp_fw(2'b01, u + 1);
    tick(1); clr_in();
    chk1("d_no_overrun", overrun_err, 1'b0);
    tick(2);
    u = cyc;
    m_finish_wresp = 1'b1;
    exp_fw(2'b10, u + 1);
    exp_mw(32'h600, {8{16'h6666}}, 16'hAAAA, u + 2);
    tick(1); clr_in();
    tick(2);

    // Overrun on req0 while its write is outstanding; set wins over clear.
    chk("e_addr_before", DW'(m_win_addr), DW'(32'h600));
    set_w(0, 32'h700, {8{16'h7777}}, 16'h0000);
    tick(1); clr_in();
    chk1("e_overrun_set", overrun_err, 1'b1);
    chk("e_addr_held", DW'(m_win_addr), DW'(32'h600));
    chk("e_data_held", m_in_wdata, {8{16'h6666}});
    err_clr = 1'b1;
    set_w(0, 32'h800, {8{16'h8888}}, 16'h0000);
    tick(1); clr_in();
    chk1("e_set_wins", overrun_err, 1'b1);
    err_clr = 1'b1;
    tick(1); clr_in();
    chk1("e_cleared", overrun_err, 1'b0);
    chk("e_mask_held", DW'(m_in_mask), DW'(16'hAAAA));
    m_finish_wresp = 1'b1;
    exp_fw(2'b01, cyc + 1);
    tick(1); clr_in();
    tick(3);
    chk1("e_dropped_not_issued", busy, 1'b0);
    m_finish_wresp = 1'b1;
    tick(1); clr_in();
    tick(1);
    chk1("e_idle_fin_ignored", busy, 1'b0);

    // Reset during RWAIT with a pending write on req1: everything discarded.
    t = cyc;
    set_r(0, 32'h900);
    exp_mr(32'h900, t + 2);
    tick(1); clr_in();
    tick(2);
    set_w(1, 32'hA00, {16{8'hAA}}, 16'h0000);
    tick(1); clr_in();
    d = {4{32'hCAFE_0001}};
    m_rdat_m_valid = 1'b1;
    m_rdat_m_data = d;
    exp_rv(2'b01, d, cyc + 1);
    tick(1); clr_in();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk1("f_rst_busy", busy, 1'b0);
    chk("f_rst_valid", DW'(req_rdat_m_valid), DW'(0));
    chk("f_rst_rdata", req_rdat_m_data, DW'(0));
    chk("f_rst_raddr", DW'(m_rin_addr), DW'(0));
    tick(2);
    rst = 1'b0;
    tick(3);
    chk1("f_pending_discarded", busy, 1'b0);
    t = cyc;
    set_w(1, 32'hB00, {16{8'h3C}}, 16'h0F0F);
    exp_mw(32'hB00, {16{8'h3C}}, 16'h0F0F, t + 2);
    tick(1); clr_in();
    tick(1);
    chk("f_owner", DW'(owner), DW'(1));
    tick(1);
    m_finish_wresp = 1'b1;
    exp_fw(2'b10, cyc + 1);
    tick(1); clr_in();
    tick(2);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: no downstream finish, synthetic finish TO cycles after issue; late finish ignored.
    t = cyc;
    set_w(0, 32'hC00, {16{8'h5A}}, 16'h0000);
    exp_mw(32'hC00, {16{8'h5A}}, 16'h0000, t + 2);
    exp_fw(2'b01, t + 2 + int'(TO));
    tick(1); clr_in();
    tick(int'(TO) + 4);
    chk1("g_timeout_err", timeout_err, 1'b1);
    chk1("g_idle", busy, 1'b0);
    m_finish_wresp = 1'b1;
    tick(1); clr_in();
    tick(2);
    err_clr = 1'b1;
    tick(1); clr_in();
    chk1("g_timeout_clr", timeout_err, 1'b0);
`else
    chk1("g_timeout_tied", timeout_err, 1'b0);
`endif

    tick(2);
    chk("q_mw_drained", DW'(q_mw.size()), DW'(0));
    chk("q_mr_drained", DW'(q_mr.size()), DW'(0));
    chk("q_fw_drained", DW'(q_fw.size()), DW'(0));
    chk("q_fr_drained", DW'(q_fr.size()), DW'(0));
    chk("q_rv_drained", DW'(q_rv.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
